cc_speed_meter: RTL and testbench
=================================

# cc_speed_meter

Pulse-rate measurement stage that sits directly upstream of the speed comparator. It synchronizes a raw sensor pulse line and counts rising edges over a fixed gate window of clock cycles. At the end of each window it latches the count onto a data bus, which feeds the comparator's data input, and flags the update with a one-cycle strobe. Its output value changes only at window boundaries, so the downstream comparator sees a stable bus between updates.

## Interface
- SPEEDMETER_DATAWIDTH, default 8: width of the count and of the output bus.
- SPEEDMETER_WINDOWCYCLES, default 50000000: gate window length in clocks (1 s at 50 MHz); legal range is ≥ 2.

Ports:
- CC_SPEEDMETER_CLOCK_50  in  1  the single clock; every flop is rising-edge.
- CC_SPEEDMETER_RESET_InHigh  in  1  reset, synchronous and active-high.
- CC_SPEEDMETER_pulse_In  in  1  raw sensor pulse, asynchronous to the clock.
- CC_SPEEDMETER_enable_InHigh  in  1  measurement enable.
- CC_SPEEDMETER_data_OutBUS  out  SPEEDMETER_DATAWIDTH  latched pulses-per-window value; drives the comparator data bus.
- CC_SPEEDMETER_valid_OutHigh  out  1  one-cycle strobe on each new value.
- CC_SPEEDMETER_overflow_OutHigh  out  1  set when the latched window saturated; held alongside data.

## Operation
- Input path:
  - Two-flop synchronizer, then a third flop for edge detection.
  - An edge is counted when the synchronized level goes from 0 to 1.
- States:
  - IDLE: enable is low. Window counter and pulse counter are held at 0. Outputs hold their last value. valid stays 0.
  - COUNT: enable is high. The window counter runs 0..SPEEDMETER_WINDOWCYCLES-1. It is $clog2(SPEEDMETER_WINDOWCYCLES) bits wide and wraps to 0.
- Transitions:
  - IDLE→COUNT on the first clock with enable high. That cycle is window cycle 0.
  - COUNT→IDLE on the first clock with enable low. The partial window is discarded: no valid strobe, no data update.
- Counting: the pulse counter increments on each detected edge and saturates at 2^W-1. A saturation flag is set on any edge that arrives while the count is already at 2^W-1.
- Terminal cycle (window counter = WINDOWCYCLES-1):
  - data is loaded with the final count, including any edge detected in that same cycle.
  - overflow is loaded with the saturation flag.
  - The pulse counter and saturation flag are cleared. An edge in the terminal cycle is never carried into the next window.
- Reset (at any time, including mid-window): the next clock returns all counters, the saturation flag, data, overflow and valid to 0, and the state to IDLE.

## Timing
- Reset values: data_OutBUS = 0, valid_OutHigh = 0, overflow_OutHigh = 0.
- Pin-to-count latency is 3 clocks (2 synchronizer stages + edge detect).
- Guaranteed detection requires the pulse to be high ≥ 2 clocks and low ≥ 2 clocks.
- data, overflow and valid all update on the clock edge that ends the terminal cycle. valid is high for exactly that following cycle.
- Consecutive valid strobes are exactly SPEEDMETER_WINDOWCYCLES clocks apart while enable stays high.
- The first valid strobe arrives SPEEDMETER_WINDOWCYCLES clocks after the first enabled cycle.

## Configuration
- SPEEDMETER_AVERAGE_EN defined:
  - data = floor((current + previous) / 2), computed with a W+1-bit sum.
  - previous is the last window's raw count. It is cleared on reset and on COUNT→IDLE, so the first window after start reports floor(current/2).
  - overflow reflects the current window only.
- SPEEDMETER_AVERAGE_EN undefined: data = raw count of the current window. No previous-count register exists.

## Test plan
All scenarios use SPEEDMETER_WINDOWCYCLES=100 and SPEEDMETER_DATAWIDTH=8 unless stated otherwise.
- Reset: assert reset 3 clocks with pulses toggling → data=0, valid=0, overflow=0. No valid strobe for 99 clocks after enable rises.
- Basic count: enable high, 10 pulses (4 high/4 low) in the first window → valid for one cycle, data=10, overflow=0. The next strobe follows exactly 100 clocks later, with data=0 if no pulses arrived.
- Boundary edge: a synchronized edge detected in the terminal cycle → counted in the closing window (data=N+1). The next window starts from 0.
- Saturation: DATAWIDTH=4, 20 pulses (2 high/2 low) in one window → data=15, overflow=1. A following window with 3 pulses → data=3, overflow=0.
- Enable/reset abort:
  - Drop enable after 5 pulses mid-window → no valid, data keeps its prior value.
  - Re-enable, then 7 pulses → data=7 exactly 100 clocks after re-enable.
  - Reset mid-window → all outputs 0 on the next clock.
- SPEEDMETER_AVERAGE_EN: windows of 10 then 20 pulses → data=5, then data=15.

Source files
------------

// File: rtl/cc_speed_meter.sv
// rtl/cc_speed_meter.sv - pulse-rate meter: sync + edge count over a gate window, latched per window.
// Optional SPEEDMETER_AVERAGE_EN: report floor((current + previous window) / 2).
module cc_speed_meter #(
    parameter int SPEEDMETER_DATAWIDTH    = 8,
    parameter int SPEEDMETER_WINDOWCYCLES = 50000000
) (
    input  logic                            CC_SPEEDMETER_CLOCK_50,
    input  logic                            CC_SPEEDMETER_RESET_InHigh,
    input  logic                            CC_SPEEDMETER_pulse_In,
    input  logic                            CC_SPEEDMETER_enable_InHigh,
    output logic [SPEEDMETER_DATAWIDTH-1:0] CC_SPEEDMETER_data_OutBUS,
    output logic                            CC_SPEEDMETER_valid_OutHigh,
    output logic                            CC_SPEEDMETER_overflow_OutHigh
);
    localparam int W  = SPEEDMETER_DATAWIDTH;
    localparam int CW = $clog2(SPEEDMETER_WINDOWCYCLES);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(SPEEDMETER_WINDOWCYCLES - 1);
    localparam logic [W-1:0]  COUNT_MAX  = '1;

    typedef enum logic {ST_IDLE, ST_COUNT} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           r_sync1;
    logic           r_sync2;
    logic           r_sync3;
    logic [CW-1:0]  r_win;
    logic [W-1:0]   r_count;
    logic           r_sat;
    logic [W-1:0]   r_data;
    logic           r_overflow;
    logic           r_valid;
    logic           w_edge;
    logic           w_active;
    logic           w_abort;
    logic           w_terminal;
    logic [W-1:0]   w_count_final;
    logic           w_sat_final;
    logic [W-1:0]   w_window_value;

    // Synchronizer is not reset so a level held across reset is not seen as a fresh edge.
    always_ff @(posedge CC_SPEEDMETER_CLOCK_50) begin
        r_sync1 <= CC_SPEEDMETER_pulse_In;
        r_sync2 <= r_sync1;
        r_sync3 <= r_sync2;
    end

    assign w_edge = r_sync2 & ~r_sync3;

    always_ff @(posedge CC_SPEEDMETER_CLOCK_50) begin
        if (CC_SPEEDMETER_RESET_InHigh) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (CC_SPEEDMETER_enable_InHigh)  w_state_next = ST_COUNT;
            ST_COUNT: if (!CC_SPEEDMETER_enable_InHigh) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // The first enabled cycle is window cycle 0 even though the state is still IDLE.
    always_comb begin
        w_active = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            ST_IDLE:  w_active = CC_SPEEDMETER_enable_InHigh;
            ST_COUNT: begin
                w_active = CC_SPEEDMETER_enable_InHigh;
                w_abort  = !CC_SPEEDMETER_enable_InHigh;
            end
            default: begin
                w_active = 1'b0;
                w_abort  = 1'b0;
            end
        endcase
        w_terminal = w_active && (r_win == LAST_CYCLE);
    end

    always_comb begin
        w_count_final = r_count;
        w_sat_final   = r_sat;
        if (w_edge) begin
            if (r_count == COUNT_MAX) begin
                w_sat_final = 1'b1;
            end else begin
                w_count_final = r_count + W'(1);
            end
        end
    end

`ifdef SPEEDMETER_AVERAGE_EN
    logic [W-1:0] r_prev;
    logic [W:0]   w_sum;

    assign w_sum          = {1'b0, w_count_final} + {1'b0, r_prev};
    assign w_window_value = w_sum[W:1];

    always_ff @(posedge CC_SPEEDMETER_CLOCK_50) begin
        if (CC_SPEEDMETER_RESET_InHigh || w_abort) begin
            r_prev <= '0;
        end else if (w_terminal) begin
            r_prev <= w_count_final;
        end
    end
`else
    assign w_window_value = w_count_final;
`endif

    always_ff @(posedge CC_SPEEDMETER_CLOCK_50) begin
        if (CC_SPEEDMETER_RESET_InHigh) begin
            r_win      <= '0;
            r_count    <= '0;
            r_sat      <= 1'b0;
            r_data     <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!w_active) begin
                r_win   <= '0;
                r_count <= '0;
                r_sat   <= 1'b0;
            end else if (w_terminal) begin
                r_win      <= '0;
                r_count    <= '0;
                r_sat      <= 1'b0;
                r_data     <= w_window_value;
                r_overflow <= w_sat_final;
                r_valid    <= 1'b1;
            end else begin
                r_win   <= r_win + CW'(1);
                r_count <= w_count_final;
                r_sat   <= w_sat_final;
            end
        end
    end

    assign CC_SPEEDMETER_data_OutBUS      = r_data;
    assign CC_SPEEDMETER_valid_OutHigh    = r_valid;
    assign CC_SPEEDMETER_overflow_OutHigh = r_overflow;

endmodule

// File: tb/tb_cc_speed_meter.sv
// tb/tb_cc_speed_meter.sv - scoreboard bench for cc_speed_meter (8-bit and 4-bit instances, 100-cycle window).
module tb_cc_speed_meter;
    localparam int WC = 100;
`ifdef SPEEDMETER_AVERAGE_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse = 1'b0;
    logic       en = 1'b0;
    logic [7:0] d8;
    logic       v8, o8;
    logic [3:0] d4;
    logic       v4, o4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cc_speed_meter #(.SPEEDMETER_DATAWIDTH(8), .SPEEDMETER_WINDOWCYCLES(WC)) u_dut8 (
        .CC_SPEEDMETER_CLOCK_50(clk), .CC_SPEEDMETER_RESET_InHigh(rst),
        .CC_SPEEDMETER_pulse_In(pulse), .CC_SPEEDMETER_enable_InHigh(en),
        .CC_SPEEDMETER_data_OutBUS(d8), .CC_SPEEDMETER_valid_OutHigh(v8),
        .CC_SPEEDMETER_overflow_OutHigh(o8));

    cc_speed_meter #(.SPEEDMETER_DATAWIDTH(4), .SPEEDMETER_WINDOWCYCLES(WC)) u_dut4 (
        .CC_SPEEDMETER_CLOCK_50(clk), .CC_SPEEDMETER_RESET_InHigh(rst),
        .CC_SPEEDMETER_pulse_In(pulse), .CC_SPEEDMETER_enable_InHigh(en),
        .CC_SPEEDMETER_data_OutBUS(d4), .CC_SPEEDMETER_valid_OutHigh(v4),
        .CC_SPEEDMETER_overflow_OutHigh(o4));

    // Reference model: total edges per window (unbounded), clipped to the width afterwards.
    int         ph = 0;
    int         cnt = 0;
    int         max_v [2] = '{255, 15};
    int         prev [2] = '{0, 0};
    int         exp_data [2] = '{0, 0};
    bit         exp_ovf [2] = '{0, 0};
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    bit         h0 = 0, h1 = 0, h2 = 0;
    bit         m_edge;
    int         m_raw, m_val;

    // An input rise sampled at clock k is counted on clock k+2 (3-clock pin-to-count latency).
    always @(posedge clk) begin
        m_edge = h1 && !h2;
        h2 = h1; h1 = h0; h0 = pulse;
        if (rst) begin
            ph = 0; cnt = 0;
            for (int d = 0; d < 2; d++) begin
                prev[d] = 0; exp_data[d] = 0; exp_ovf[d] = 0;
            end
        end else if (en) begin
            if (m_edge) cnt++;
            if (ph == WC - 1) begin
                for (int d = 0; d < 2; d++) begin
                    m_raw = (cnt > max_v[d]) ? max_v[d] : cnt;
                    m_val = AVG ? (m_raw + prev[d]) / 2 : m_raw;
                    exp_data[d] = m_val;
                    exp_ovf[d]  = (cnt > max_v[d]);
                    prev[d]     = m_raw;
                    if (d == 0) q0.push_back({exp_ovf[d], 8'(m_val)});
                    else        q1.push_back({exp_ovf[d], 8'(m_val)});
                end
                cnt = 0; ph = 0;
            end else begin
                ph++;
            end
        end else begin
            ph = 0; cnt = 0; prev[0] = 0; prev[1] = 0;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic mon(input int d, input bit v, input int data, input bit ovf);
        logic [8:0] e;
        bit have;
        have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (v || have) begin
            n_tests++;
            if (!have) begin
                n_fail++;
                $display("FAIL unexpected_valid[%0d]: got valid=1 expected valid=0", d);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                if (!v) begin
                    n_fail++;
                    $display("FAIL missing_valid[%0d]: got valid=0 expected valid=1", d);
                end else if (e != {ovf, 8'(data)}) begin
                    n_fail++;
                    $display("FAIL window_result[%0d]: got data=%0d ovf=%0d expected data=%0d ovf=%0d",
                             d, data, ovf, e[7:0], e[8]);
                end
            end
        end
        chk($sformatf("hold_data[%0d]", d), data, exp_data[d]);
        chk($sformatf("hold_ovf[%0d]", d), int'(ovf), int'(exp_ovf[d]));
    endtask

    always @(negedge clk) begin
        mon(0, v8, int'(d8), o8);
        mon(1, v4, int'(d4), o4);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_train(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            pulse = 1'b1; repeat (hi) tick();
            pulse = 1'b0; repeat (lo) tick();
        end
    endtask

    task automatic wait_phase(input int p);
        int i;
        i = 0;
        while (ph != p && i < 2 * WC) begin tick(); i++; end
        chk("wait_phase_reached", ph, p);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin tick(); n++; end while (!v8 && n < 2 * WC);
        chk("valid_seen", int'(v8), 1);
    endtask

    int n, t;

    initial begin
        rst = 1; en = 0; pulse = 0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin pulse = ~pulse; tick(); end
        pulse = 0; repeat (3) tick();
        chk("reset_data8", int'(d8), 0); chk("reset_valid8", int'(v8), 0);
        chk("reset_ovf8", int'(o8), 0);  chk("reset_data4", int'(d4), 0);

        rst = 0; en = 1;
        pulse_train(10, 4, 4);
        wait_valid(n);
        chk("first_strobe_latency", 80 + n, WC);
        chk("basic_data", int'(d8), AVG ? 5 : 10); chk("basic_ovf", int'(o8), 0);
        wait_valid(n);
        chk("strobe_period", n, WC);
        chk("empty_window", int'(d8), AVG ? 5 : 0);

        wait_phase(10); pulse_train(3, 3, 3);
        wait_phase(WC - 3); pulse = 1; tick(); tick(); pulse = 0;
        wait_valid(n);
        chk("boundary_edge", int'(d8), AVG ? 2 : 4);
        wait_valid(n);
        chk("after_boundary", int'(d8), AVG ? 2 : 0);

        pulse_train(20, 2, 2);
        wait_valid(n);
        chk("sat_data4", int'(d4), AVG ? 7 : 15); chk("sat_ovf4", int'(o4), 1);
        chk("nosat_data8", int'(d8), AVG ? 10 : 20); chk("nosat_ovf8", int'(o8), 0);
        pulse_train(3, 2, 2);
        wait_valid(n);
        chk("post_sat_data4", int'(d4), AVG ? 9 : 3); chk("post_sat_ovf4", int'(o4), 0);

        t = int'(d8);
        pulse_train(5, 3, 3);
        en = 0; repeat (10) tick();
        chk("abort_keeps_data", int'(d8), t);
        en = 1;
        pulse_train(7, 3, 3);
        wait_valid(n);
        chk("reenable_latency", 42 + n, WC);
        chk("reenable_data", int'(d8), AVG ? 3 : 7);

        pulse_train(4, 3, 3);
        rst = 1; tick();
        chk("midreset_data8", int'(d8), 0); chk("midreset_valid8", int'(v8), 0);
        chk("midreset_ovf4", int'(o4), 0);  chk("midreset_data4", int'(d4), 0);
        rst = 0;

        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 11))
                0: begin en = 0; repeat ($urandom_range(1, 30)) tick(); en = 1; end
                1: begin rst = 1; tick(); rst = 0; end
                2: repeat ($urandom_range(1, 40)) tick();
                default: pulse_train($urandom_range(1, 6), $urandom_range(2, 5), $urandom_range(2, 5));
            endcase
        end

        pulse = 0;
        repeat (WC + 10) tick();
        en = 0; repeat (3) tick();
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
